// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg
//   Shared definitions for the program sequencer: the default instruction
//   width, the sequencer state encoding and field extractors for the
//   {opcode[2:0], op1[3:0], op2[3:0]} instruction format.
package program_sequencer_pkg;

    localparam int SEQ_INSTR_W = 11;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_HOLD  = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    function automatic logic [2:0] get_opcode(input logic [SEQ_INSTR_W-1:0] instr);
        return instr[10:8];
    endfunction

    function automatic logic [3:0] get_op1(input logic [SEQ_INSTR_W-1:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [3:0] get_op2(input logic [SEQ_INSTR_W-1:0] instr);
        return instr[3:0];
    endfunction

endpackage

// File: rtl/program_sequencer_prog_ram.sv
// program_sequencer_prog_ram
//   Program image store: DATA_W x 2**ADDR_W words, single write port and a
//   registered, enabled read port. The array itself is never reset; only the
//   read register is, so the presented instruction starts at zero.
// Ports:
//   clk, reset_n      clock / async active-low reset of the read register
//   we, waddr, wdata  write port
//   re, raddr         read enable / address (data appears after the edge)
//   rdata             registered read data, holds while re=0
module program_sequencer_prog_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer
//   Instruction-issue stage feeding cpu_top. Holds a program in an internal
//   RAM, walks a program counter and presents each instruction for
//   CYC_PER_INS clocks, stopping after prog_len instructions or on stop.
// Ports:
//   clk, reset_n             clock / async active-low reset
//   load_we/addr/data        program write port (dropped while busy)
//   prog_len                 instructions to run, sampled on start
//   start, stop              run request / abort at next instruction boundary
//   step (SEQ_STEP_EN only)  single-step release of the last hold phase
//   instruction, instr_valid presented instruction / first-clock strobe
//   pc                       address of the presented instruction
//   busy, done               running / finished
// Build option: define SEQ_STEP_EN to add the step input.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = SEQ_INSTR_W,
    parameter int CYC_PER_INS = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    input  logic               stop,
`ifdef SEQ_STEP_EN
    input  logic               step,
`endif
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done
);

    localparam int              PH_W    = $clog2(CYC_PER_INS + 1);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(CYC_PER_INS - 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    seq_state_e        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    // fetch_q is the address being read; pc_q follows it when the read data
    // lands, so pc always names the instruction actually on the bus.
    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              stop_seen_q, stop_seen_d;
    logic              instr_valid_q, instr_valid_d;

    logic step_ok;
    logic is_last;
    logic ram_we;
    logic ram_re;

`ifdef SEQ_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    // Compare fetch+1 against len so len=2**ADDR_W needs no underflow case.
    assign is_last = (({1'b0, fetch_q} + LEN_ONE) == len_q);
    assign busy    = (state_q == SEQ_ISSUE) || (state_q == SEQ_HOLD);
    assign done    = (state_q == SEQ_DONE);
    assign ram_we  = load_we && !busy;
    assign ram_re  = (state_q == SEQ_ISSUE);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        fetch_d       = fetch_q;
        pc_d          = pc_q;
        len_d         = len_q;
        stop_seen_d   = stop_seen_q;
        instr_valid_d = (state_q == SEQ_ISSUE);
        case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
                if (start) begin
                    len_d       = prog_len;
                    fetch_d     = '0;
                    pc_d        = '0;
                    phase_d     = '0;
                    stop_seen_d = 1'b0;
                    state_d     = (prog_len == '0) ? SEQ_DONE : SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                phase_d = PH_ONE;
                pc_d    = fetch_q;
                state_d = SEQ_HOLD;
                if (stop) stop_seen_d = 1'b1;
            end
            SEQ_HOLD: begin
                if (stop) stop_seen_d = 1'b1;
                if (phase_q != LAST_PH) begin
                    phase_d = phase_q + PH_ONE;
                end else if (step_ok) begin
                    phase_d = '0;
                    // A stop arriving on the boundary clock itself still ends the run here.
                    if (stop_seen_q || stop || is_last) begin
                        state_d = SEQ_DONE;
                    end else begin
                        fetch_d = fetch_q + 1'b1;
                        state_d = SEQ_ISSUE;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEQ_IDLE;
            phase_q       <= '0;
            fetch_q       <= '0;
            pc_q          <= '0;
            len_q         <= '0;
            stop_seen_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            fetch_q       <= fetch_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            stop_seen_q   <= stop_seen_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // The RAM read register doubles as the instruction register: loaded only
    // during ISSUE, so it holds through HOLD and after the run ends.
    program_sequencer_prog_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(INSTR_W)
    ) u_prog_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (ram_we),
        .waddr  (load_addr),
        .wdata  (load_data),
        .re     (ram_re),
        .raddr  (fetch_q),
        .rdata  (instruction)
    );

    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer
//   Directed bench for program_sequencer with a time-based reference model
//   (instruction k of a run is presented from clock 3k+1 after start) checked
//   every cycle, plus hand-computed expectations per scenario.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_we = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [10:0] load_data = '0;
    logic [8:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef SEQ_STEP_EN
    logic        step = 1'b1;
`endif
    logic [10:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b1;

    program_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .prog_len   (prog_len),
        .start      (start),
        .stop       (stop),
`ifdef SEQ_STEP_EN
        .step       (step),
`endif
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] pat(input int i);
        return 11'((i * 37) ^ 341);
    endfunction

    // Reference model: outputs as a function of clocks elapsed since start.
    logic [10:0] mem_m [0:255];
    logic [10:0] m_instr = '0;
    logic [7:0]  m_pc = '0;
    logic        m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int          m_t = 0, m_len = 0, m_k = 0;
    bit          m_stop = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_instr = '0; m_pc = '0; m_valid = 0; m_busy = 0; m_done = 0;
                m_t = 0; m_stop = 0;
            end else begin
                if (load_we && !m_busy) mem_m[load_addr] = load_data;
                if (!m_busy) begin
                    m_valid = 0;
                    if (start) begin
                        m_len = int'(prog_len); m_stop = 0; m_pc = '0; m_t = 0;
                        m_busy = (m_len != 0); m_done = (m_len == 0);
                    end
                end else begin
                    m_t++;
                    if (stop) m_stop = 1;
                    m_k = (m_t - 1) / 3;
                    m_valid = (m_t % 3 == 1);
                    if (m_valid) begin
                        m_instr = mem_m[m_k];
                        m_pc = 8'(m_k);
                    end
                    if ((m_t % 3 == 0) && (m_stop || m_k == m_len - 1)) begin
                        m_busy = 0; m_done = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("cyc_instr", 32'(instruction), 32'(m_instr));
            chk("cyc_valid", 32'(instr_valid), 32'(m_valid));
            chk("cyc_pc", 32'(pc), 32'(m_pc));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            if (instr_valid)
                $display("issue pc=%0d instr=%03h op=%0d a=%0d b=%0d", pc, instruction,
                         get_opcode(instruction), get_op1(instruction), get_op2(instruction));
        end
    end

    int          tq[$];
    logic [7:0]  pq[$];
    logic [10:0] iq[$];

    task automatic load(input int a, input logic [10:0] d);
        load_we = 1; load_addr = 8'(a); load_data = d;
        @(negedge clk);
        load_we = 0;
    endtask

    task automatic start_run(input int len);
        prog_len = 9'(len); start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // Runs until done (bounded); t counts clocks after the start edge.
    task automatic wait_done(input int maxc, input int stop_t, input int inj_t, output int t);
        tq.delete(); pq.delete(); iq.delete();
        t = 0;
        while (done !== 1'b1 && t < maxc) begin
            stop = (t == stop_t);
            if (t == inj_t) begin
                load_we = 1; load_addr = 8'd1; load_data = 11'h7FF; start = 1; prog_len = 9'd2;
            end else begin
                load_we = 0; start = 0;
            end
            @(negedge clk);
            t++;
            if (instr_valid) begin
                tq.push_back(t); pq.push_back(pc); iq.push_back(instruction);
            end
        end
        stop = 0; load_we = 0; start = 0;
        chk("run_ends", 32'(done), 32'd1);
        $display("run len=%0d ended after %0d clocks, %0d issues", prog_len, t, tq.size());
    endtask

    initial begin
        int t;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_n = 1;
        @(negedge clk);

        for (int i = 0; i < 256; i++) load(i, pat(i));
        load(0, 11'h012); load(1, 11'h131); load(2, 11'h444); load(3, 11'h550);
        load(4, 11'h7A3); load(5, 11'h2C9); load(6, 11'h615); load(7, 11'h0F0);

        // stop in IDLE ignored, then len=0 goes straight to DONE
        stop = 1; repeat (3) @(negedge clk); stop = 0;
        chk("idle_stop_busy", 32'(busy), 32'd0);
        start_run(0);
        chk("len0_done", 32'(done), 32'd1);
        wait_done(5, -1, -1, t);
        chk("len0_t", 32'(t), 32'd0);
        n = 0;
        repeat (4) begin @(negedge clk); if (instr_valid) n++; end
        chk("len0_novalid", 32'(n), 32'd0);
        chk("len0_instr", 32'(instruction), 32'd0);

        // four-instruction program
        start_run(4);
        wait_done(40, -1, -1, t);
        chk("p4_done_at", 32'(t), 32'd12);
        chk("p4_issues", 32'(tq.size()), 32'd4);
        if (tq.size() == 4) begin
            chk("p4_t0", 32'(tq[0]), 32'd1);  chk("p4_t3", 32'(tq[3]), 32'd10);
            chk("p4_i0", 32'(iq[0]), 32'h012); chk("p4_i1", 32'(iq[1]), 32'h131);
            chk("p4_i2", 32'(iq[2]), 32'h444); chk("p4_i3", 32'(iq[3]), 32'h550);
            chk("p4_pc3", 32'(pq[3]), 32'd3);
        end

        // stop during pc=2 hold
        start_run(6);
        wait_done(40, 7, -1, t);
        chk("stop_done_at", 32'(t), 32'd9);
        chk("stop_issues", 32'(tq.size()), 32'd3);
        chk("stop_pc", 32'(pc), 32'd2);
        chk("stop_busy", 32'(busy), 32'd0);

        // stop on the final boundary clock
        start_run(2);
        wait_done(20, 5, -1, t);
        chk("fstop_done_at", 32'(t), 32'd6);
        chk("fstop_pc", 32'(pc), 32'd1);
        @(negedge clk);
        chk("fstop_still_done", 32'(done), 32'd1);

        // load/start while busy are ignored
        start_run(5);
        wait_done(40, -1, 5, t);
        chk("busy_done_at", 32'(t), 32'd15);
        chk("busy_issues", 32'(tq.size()), 32'd5);
        if (tq.size() == 5) chk("busy_i1", 32'(iq[1]), 32'h131);
        start_run(2);
        wait_done(20, -1, -1, t);
        if (iq.size() == 2) chk("readback_i1", 32'(iq[1]), 32'h131);

        // load and start on the same clock
        load_we = 1; load_addr = 8'd0; load_data = 11'h3AB;
        start_run(1);
        load_we = 0;
        wait_done(20, -1, -1, t);
        chk("ldst_done_at", 32'(t), 32'd3);
        if (iq.size() == 1) chk("ldst_i0", 32'(iq[0]), 32'h3AB);
        load(0, 11'h012);

        // reset mid-run at pc=5
        start_run(8);
        n = 0;
        while (!(instr_valid && pc == 8'd5) && n < 40) begin @(negedge clk); n++; end
        chk("rst_reach_pc5", 32'(pc), 32'd5);
        @(posedge clk); #2 reset_n = 0; #1;
        chk("mrst_instr", 32'(instruction), 32'd0);
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_pc", 32'(pc), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        @(posedge clk); #2 reset_n = 1;
        @(negedge clk);
        start_run(8);
        wait_done(40, -1, -1, t);
        chk("rerun_issues", 32'(tq.size()), 32'd8);
        if (iq.size() == 8) begin
            chk("rerun_i0", 32'(iq[0]), 32'h012);
            chk("rerun_i5", 32'(iq[5]), 32'h2C9);
        end

        // full-depth run, pc wraps only on next start
        start_run(256);
        wait_done(800, -1, -1, t);
        chk("full_done_at", 32'(t), 32'd768);
        chk("full_issues", 32'(tq.size()), 32'd256);
        chk("full_pc", 32'(pc), 32'd255);
        chk("full_last", 32'(instruction), 32'(pat(255)));
        start_run(1);
        wait_done(20, -1, -1, t);
        if (pq.size() == 1) chk("wrap_pc", 32'(pq[0]), 32'd0);

`ifdef SEQ_STEP_EN
        chk_en = 0;
        step = 0;
        start_run(3);
        repeat (10) @(negedge clk);
        chk("step_pc0", 32'(pc), 32'd0);
        chk("step_i0", 32'(instruction), 32'h012);
        chk("step_busy", 32'(busy), 32'd1);
        step = 1; @(negedge clk); step = 0;
        repeat (3) @(negedge clk);
        chk("step_pc1", 32'(pc), 32'd1);
        chk("step_i1", 32'(instruction), 32'h131);
        @(posedge clk); #2 reset_n = 0;
        @(posedge clk); #2 reset_n = 1;
        step = 1;
        @(negedge clk);
        chk_en = 1;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
